// File: rtl/line_window_pkg.sv
// Shared constants, types and helpers for the KxK line window generator.
package line_window_pkg;

  // Legal range of the window edge.
  localparam int unsigned KERNEL_MIN = 2;
  localparam int unsigned KERNEL_MAX = 7;

  // Border handling selected by border_mode.
  localparam logic BORDER_ZERO = 1'b0;
  localparam logic BORDER_REPL = 1'b1;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } state_e;

  // Flat tap index of row r, column c in a k-wide window.
  function automatic int unsigned tap_index(input int unsigned r, input int unsigned c,
                                            input int unsigned k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/line_window_gen_if.sv
// Pixel stream in / window stream out bundle of the line window generator.
interface line_window_gen_if #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned KERNEL    = 3,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9
);

  logic                               in_valid;
  logic                               in_sof;
  logic                               in_eol;
  logic [WORD_SIZE-1:0]               in_pixel;
  logic                               border_mode;

  logic                               out_valid;
  logic [KERNEL*KERNEL*WORD_SIZE-1:0] out_window;
  logic [X_W-1:0]                     out_x;
  logic [Y_W-1:0]                     out_y;
  logic                               out_sof;

  // Pixel source / window consumer side.
  modport master (
    output in_valid, in_sof, in_eol, in_pixel, border_mode,
    input  out_valid, out_window, out_x, out_y, out_sof
  );

  // Window generator side.
  modport slave (
    input  in_valid, in_sof, in_eol, in_pixel, border_mode,
    output out_valid, out_window, out_x, out_y, out_sof
  );

endinterface

// File: rtl/line_buffer.sv
// One line of pixel history: single port, read-before-write, one access per accepted pixel.
module line_buffer #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ROW_SIZE  = 640,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                 clock,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 we,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);

  localparam int unsigned AW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;

  logic [WORD_SIZE-1:0] mem [ROW_SIZE];
  logic [AW-1:0]        idx;

  assign idx = addr[AW-1:0];

  // Asynchronous read returns the old word in the same cycle it gets overwritten.
  assign rdata = mem[idx];

  // Write the new word at the end of the accept cycle.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: rtl/line_window_gen.sv
// Causal KxK neighbourhood generator with internal line buffers and border substitution.
module line_window_gen
  import line_window_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned ROW_SIZE  = 640,
  parameter int unsigned KERNEL    = 3,
  parameter int unsigned X_W       = 10,
  parameter int unsigned Y_W       = 9
) (
  input logic              clock,
  input logic              reset,
  line_window_gen_if.slave bus
);

  localparam int unsigned K     = KERNEL;
  localparam int unsigned NB    = K - 1;
  localparam int unsigned WIN_W = K * K * WORD_SIZE;

  if (KERNEL < KERNEL_MIN || KERNEL > KERNEL_MAX) begin : g_bad_kernel
    $error("line_window_gen: KERNEL must be within 2..7");
  end
  if ((64'd1 << X_W) < 64'(ROW_SIZE)) begin : g_bad_xw
    $error("line_window_gen: X_W too narrow for ROW_SIZE");
  end

  typedef logic [WORD_SIZE-1:0] word_t;

  state_e           state;
  logic [X_W-1:0]   next_x;
  logic [Y_W-1:0]   next_y;
  word_t            win    [K][K];
  word_t            nwin   [K][K];
  word_t            col    [K];
  word_t            buf_rd [NB];
  word_t            buf_wr [NB];
  logic [WIN_W-1:0] sub_window;

  logic             accept;
  logic             wrap;
  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic [X_W-1:0]   x_after;
  logic [Y_W-1:0]   y_after;

  // Accept decode, coordinates of the incoming pixel and of the one after it.
  always_comb begin
    accept  = bus.in_valid & ((state == StActive) | bus.in_sof);
    cur_x   = bus.in_sof ? '0 : next_x;
    cur_y   = bus.in_sof ? '0 : next_y;
    wrap    = bus.in_eol | (cur_x == X_W'(ROW_SIZE - 1));
    x_after = wrap ? '0 : cur_x + 1'b1;
    y_after = cur_y;
    if (wrap && (cur_y != '1)) begin
      y_after = cur_y + 1'b1;
    end
  end

  // Buffer 0 keeps row y-1; each further buffer takes the row its predecessor evicts.
  for (genvar i = 0; i < NB; i++) begin : g_buf
    if (i == 0) begin : g_first
      assign buf_wr[i] = bus.in_pixel;
    end else begin : g_chain
      assign buf_wr[i] = buf_rd[i-1];
    end

    line_buffer #(
      .WORD_SIZE(WORD_SIZE),
      .ROW_SIZE (ROW_SIZE),
      .ADDR_W   (X_W)
    ) u_buf (
      .clock(clock),
      .addr (cur_x),
      .we   (accept),
      .wdata(buf_wr[i]),
      .rdata(buf_rd[i])
    );
  end

  // Column entering the window: oldest row at r=0, current pixel at r=K-1.
  assign col[K-1] = bus.in_pixel;
  for (genvar r = 0; r < K - 1; r++) begin : g_col
    assign col[r] = buf_rd[K-2-r];
  end

  // Raw window after this accept: shift toward c=0, new column at c=K-1.
  always_comb begin
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        nwin[r][c] = win[r][c+1];
      end
      nwin[r][K-1] = col[r];
    end
  end

  // Border substitution so taps outside the frame never expose stale history.
  always_comb begin
    int unsigned xv, yv, d, e, sd, se, rsel, csel;
    logic        oob;
    word_t       tap, repl_val;
    sub_window = '0;
    xv = 32'(cur_x);
    yv = 32'(cur_y);
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K; c++) begin
        d    = K - 1 - r;
        e    = K - 1 - c;
        oob  = (d > yv) || (e > xv);
        sd   = (d > yv) ? yv : d;
        se   = (e > xv) ? xv : e;
        rsel = K - 1 - sd;
        csel = K - 1 - se;
        repl_val = '0;
        for (int unsigned rr = 0; rr < K; rr++) begin
          for (int unsigned cc = 0; cc < K; cc++) begin
            if (rr == rsel && cc == csel) begin
              repl_val = nwin[rr][cc];
            end
          end
        end
        tap = '0;
        unique case (bus.border_mode)
          BORDER_ZERO: tap = oob ? '0 : nwin[r][c];
          BORDER_REPL: tap = repl_val;
        endcase
        sub_window[tap_index(r, c, K)*WORD_SIZE +: WORD_SIZE] = tap;
      end
    end
  end

  // Frame FSM, counters, window registers and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= StIdle;
      next_x         <= '0;
      next_y         <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sof    <= 1'b0;
      bus.out_window <= '0;
      bus.out_x      <= '0;
      bus.out_y      <= '0;
    end else begin
      bus.out_valid <= accept;
      bus.out_sof   <= accept & bus.in_sof;
      if (accept) begin
        state          <= StActive;
        next_x         <= x_after;
        next_y         <= y_after;
        win            <= nwin;
        bus.out_window <= sub_window;
        bus.out_x      <= cur_x;
        bus.out_y      <= cur_y;
      end
    end
  end

endmodule

// File: tb/tb_line_window_gen.sv
// Directed bench for line_window_gen: K=3, 8-bit pixels, 4-pixel lines, ramp 16y+x+1.
module tb_line_window_gen;

  localparam int unsigned WS = 8;
  localparam int unsigned RS = 4;
  localparam int unsigned KK = 3;
  localparam int unsigned XW = 2;
  localparam int unsigned YW = 9;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  line_window_gen_if #(.WORD_SIZE(WS), .KERNEL(KK), .X_W(XW), .Y_W(YW)) bus ();

  line_window_gen #(
    .WORD_SIZE(WS),
    .ROW_SIZE (RS),
    .KERNEL   (KK),
    .X_W      (XW),
    .Y_W      (YW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  typedef struct {
    int          x;
    int          y;
    bit          mode;
    bit          has;
    logic [71:0] win;
  } vec_t;

  vec_t vecs [24];
  int   checks    = 0;
  int   errors    = 0;
  int   pulse_cnt = 0;

  always @(negedge clock) if (bus.out_valid) pulse_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'(16 * y + x + 1);
  endfunction

  // Reference window for a ramp frame, straight from the border rule.
  function automatic logic [71:0] model_win(input int x, input int y, input bit repl);
    logic [71:0] w;
    int d, e, dd, ee;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        d  = 2 - r;
        e  = 2 - c;
        dd = (d > y) ? y : d;
        ee = (e > x) ? x : e;
        if (!repl && (d > y || e > x)) w[(r*3+c)*8 +: 8] = 8'h00;
        else                           w[(r*3+c)*8 +: 8] = pix(x - ee, y - dd);
      end
    end
    return w;
  endfunction

  task automatic send(input bit sof, input bit eol, input logic [7:0] p, input bit mode);
    bus.in_valid    = 1'b1;
    bus.in_sof      = sof;
    bus.in_eol      = eol;
    bus.in_pixel    = p;
    bus.border_mode = mode;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_eol   = 1'b0;
  endtask

  task automatic ramp_px(input int x, input int y, input bit mode, input bit sof);
    send(sof, x == RS - 1, pix(x, y), mode);
  endtask

  task automatic expect_out(input string tag, input int x, input int y, input bit sof,
                            input logic [71:0] win);
    check({tag, ".valid"}, 72'(bus.out_valid), 72'd1);
    check({tag, ".sof"}, 72'(bus.out_sof), 72'(sof));
    check({tag, ".x"}, 72'(bus.out_x), 72'(x));
    check({tag, ".y"}, 72'(bus.out_y), 72'(y));
    check({tag, ".window"}, bus.out_window, win);
  endtask

  task automatic idle(input int n, input string tag, input logic [71:0] held);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      check({tag, ".gap_valid"}, 72'(bus.out_valid), 72'd0);
      check({tag, ".gap_hold"}, bus.out_window, held);
    end
  endtask

  initial begin
    int base;
    int n;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_sof      = 1'b0;
    bus.in_eol      = 1'b0;
    bus.in_pixel    = '0;
    bus.border_mode = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    check("reset.valid", 72'(bus.out_valid), 72'd0);
    check("reset.sof", 72'(bus.out_sof), 72'd0);
    check("reset.window", bus.out_window, 72'd0);
    check("reset.x", 72'(bus.out_x), 72'd0);
    check("reset.y", 72'(bus.out_y), 72'd0);

    // Two ramp frames (zero, then replicate); hand windows override the model.
    n = 0;
    for (int m = 0; m < 2; m++) begin
      for (int y = 0; y < 3; y++) begin
        for (int x = 0; x < 4; x++) begin
          vecs[n] = '{x: x, y: y, mode: bit'(m), has: 1'b0, win: '0};
          n++;
        end
      end
    end
    vecs[0].has  = 1'b1; vecs[0].win  = 72'h01_00_00_00_00_00_00_00_00;
    vecs[3].has  = 1'b1; vecs[3].win  = 72'h04_03_02_00_00_00_00_00_00;
    vecs[5].has  = 1'b1; vecs[5].win  = 72'h12_11_00_02_01_00_00_00_00;
    vecs[10].has = 1'b1; vecs[10].win = 72'h23_22_21_13_12_11_03_02_01;
    vecs[12].has = 1'b1; vecs[12].win = 72'h01_01_01_01_01_01_01_01_01;
    vecs[16].has = 1'b1; vecs[16].win = 72'h11_11_11_01_01_01_01_01_01;
    vecs[17].has = 1'b1; vecs[17].win = 72'h12_11_11_02_01_01_02_01_01;
    vecs[22].has = 1'b1; vecs[22].win = 72'h23_22_21_13_12_11_03_02_01;

    for (int i = 0; i < 24; i++) begin
      bit sof;
      sof = (vecs[i].x == 0) && (vecs[i].y == 0);
      ramp_px(vecs[i].x, vecs[i].y, vecs[i].mode, sof);
      expect_out($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, sof,
                 vecs[i].has ? vecs[i].win : model_win(vecs[i].x, vecs[i].y, vecs[i].mode));
    end

    // Gapped frame: one pulse per pixel, window held through the gaps.
    @(posedge clock);
    #1;
    base = pulse_cnt;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        ramp_px(x, y, 1'b0, x == 0 && y == 0);
        expect_out($sformatf("gap_%0d_%0d", x, y), x, y, x == 0 && y == 0, model_win(x, y, 0));
        idle(3, $sformatf("gap_%0d_%0d", x, y), model_win(x, y, 0));
      end
    end
    check("gap.pulses", 72'(pulse_cnt - base), 72'd12);

    // All-0xFF frame, reset mid-frame, sof-less pixels dropped, then a clean ramp.
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 4; x++) begin
        if (y == 1 && x == 2) break;
        send(x == 0 && y == 0, x == 3, 8'hFF, 1'b0);
      end
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("midreset.valid", 72'(bus.out_valid), 72'd0);
    check("midreset.window", bus.out_window, 72'd0);
    check("midreset.x", 72'(bus.out_x), 72'd0);
    check("midreset.y", 72'(bus.out_y), 72'd0);
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 1'b0, 8'hFF, 1'b0);
      check($sformatf("nosof%0d.valid", i), 72'(bus.out_valid), 72'd0);
    end
    for (int i = 0; i < 6; i++) begin
      ramp_px(i % 4, i / 4, 1'b0, i == 0);
      expect_out($sformatf("after_reset%0d", i), i % 4, i / 4, i == 0, model_win(i % 4, i / 4, 0));
      if (i == 0) check("after_reset.w00", bus.out_window, 72'h01_00_00_00_00_00_00_00_00);
      if (i == 5) check("after_reset.w11", bus.out_window, 72'h12_11_00_02_01_00_00_00_00);
    end

    // Auto-wrap at ROW_SIZE without eol.
    for (int i = 0; i < 5; i++) begin
      send(i == 0, 1'b0, 8'(i), 1'b0);
      check($sformatf("wrap%0d.x", i), 72'(bus.out_x), 72'(i % 4));
      check($sformatf("wrap%0d.y", i), 72'(bus.out_y), 72'(i / 4));
    end

    // One-pixel line: sof together with eol.
    send(1'b1, 1'b1, 8'h55, 1'b0);
    expect_out("sofeol", 0, 0, 1'b1, 72'h55_00_00_00_00_00_00_00_00);
    send(1'b0, 1'b0, 8'h66, 1'b0);
    check("sofeol_next.x", 72'(bus.out_x), 72'd0);
    check("sofeol_next.y", 72'(bus.out_y), 72'd1);
    check("sofeol_next.sof", 72'(bus.out_sof), 72'd0);

    // sof injected mid-frame at (2,1) restarts at (0,0).
    for (int i = 0; i < 6; i++) ramp_px(i % 4, i / 4, 1'b0, i == 0);
    send(1'b1, 1'b0, 8'hA5, 1'b0);
    expect_out("midsof", 0, 0, 1'b1, 72'hA5_00_00_00_00_00_00_00_00);

    // Row counter saturates at 2^Y_W-1.
    send(1'b1, 1'b1, 8'h01, 1'b0);
    for (int k = 1; k <= 515; k++) begin
      send(1'b0, 1'b1, 8'(k), 1'b0);
      if (k == 511 || k == 515) begin
        check($sformatf("ysat%0d.y", k), 72'(bus.out_y), 72'd511);
        check($sformatf("ysat%0d.x", k), 72'(bus.out_x), 72'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_window_gen.md
Name: line_window_gen

Overview:
- Parametrised causal KxK neighbourhood generator for the streaming pixel pipeline (Sobel and successor filters) between the pixel source and the kernel arithmetic.
- Keeps K-1 internal line buffers addressed by its own column counter. It needs no external AH/AV.
- Gives a valid-qualified window with per-pixel coordinates and selectable border handling (zero-pad or replicate), so out-of-frame taps never expose stale data.

Parameters:
- WORD_SIZE, 16, bits per pixel.
- ROW_SIZE, 640, active pixels per line; line buffer depth.
- KERNEL, 3, window edge K. Legal range 2..7; elaboration error outside it.
- X_W, 10, column counter width. Requires 2^X_W >= ROW_SIZE.
- Y_W, 9, row counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  pixel qualifier. Gaps allowed; no backpressure.
- in_sof  in  1  with in_valid: this pixel is (0,0) of a new frame.
- in_eol  in  1  with in_valid: this pixel is the last of its line.
- in_pixel  in  WORD_SIZE  pixel data.
- border_mode  in  1  0 = zero-pad, 1 = replicate. Sampled per accepted pixel.
- out_valid  out  1  one-cycle pulse per accepted pixel.
- out_window  out  K*K*WORD_SIZE  tap (r,c) at [(r*K+c)*WORD_SIZE +: WORD_SIZE]. r=0 is the oldest row, c=0 the oldest column; (K-1,K-1) is the current pixel.
- out_x  out  X_W  column of the current pixel.
- out_y  out  Y_W  row of the current pixel.
- out_sof  out  1  high with out_valid for pixel (0,0).

Behaviour:
- Reset:
  - out_valid, out_sof, out_window, out_x and out_y all go to 0.
  - FSM enters IDLE and the counters clear.
  - Line buffer RAM is not reset.
- FSM, IDLE:
  - Accepted pixels without in_sof are dropped; out_valid stays 0.
  - in_valid & in_sof goes to ACTIVE and processes that pixel as (0,0).
- FSM, ACTIVE:
  - Every in_valid pixel is accepted.
  - in_sof at any point restarts at (0,0); the rest of the old frame is discarded.
  - Reset mid-frame goes to IDLE, and the next frame needs in_sof.
- Counters, on accept:
  - After in_eol, or when x = ROW_SIZE-1 (auto-wrap), the next pixel gets x=0, y+1.
  - Otherwise the next pixel gets x+1.
  - y saturates at 2^Y_W-1.
  - in_sof together with in_eol is a legal 1-pixel line.
- Line buffers:
  - K-1 read-before-write buffers, all indexed by x.
  - On accept: buf[0][x] <= in_pixel and buf[i][x] <= old buf[i-1][x].
  - Read data gives the column entering the window: rows y-1 .. y-(K-1).
- Window registers:
  - KxK registers. On accept, each row shifts toward c=0.
  - Column K-1 loads {buffer reads, in_pixel}.
  - Registers hold while in_valid=0.
- Border substitution, registered into out_window:
  - Tap at row offset d = K-1-r and column offset e = K-1-c is out of frame when d>y or e>x.
  - Zero mode: an out-of-frame tap reads 0.
  - Replicate mode: use offsets min(d,y) and min(e,x), i.e. the nearest row 0 or column 0 sample.
- Latency:
  - A pixel accepted in cycle n gives out_valid=1 in cycle n+1, with the window that includes it.
  - out_window, out_x and out_y hold until the next accept.
- Consequence: after reset or in_sof, stale buffer contents never appear in out_window.

Decomposition:
- Package line_window_pkg holds:
  - the KERNEL legal-range constants;
  - a function to compute the tap index (r*K+c);
  - the border-mode encodings BORDER_ZERO=0 and BORDER_REPL=1.
- Sub-module line_buffer: single-port, read-before-write, ROW_SIZE x WORD_SIZE, one read and one write per accept. It is instantiated K-1 times.

Test Plan:
- Common setup for all cases: K=3, WORD_SIZE=8, ROW_SIZE=4, pixel(x,y) = 16y+x+1, eol on x=3.
1. Zero mode, pixel (0,0)=0x01 -> one cycle later out_valid=1, out_sof=1, window = [0,0,0, 0,0,0, 0,0,0x01].
2. Zero mode, pixel (1,1)=0x12 -> window = [0,0,0, 0,0x01,0x02, 0,0x11,0x12], out_x=1, out_y=1.
3. Replicate mode, pixel (1,1) -> window = [01,01,02, 01,01,02, 11,11,12]. At (2,2)=0x23 -> [01,02,03, 11,12,13, 21,22,23] in both modes.
4. Full 4x3 frame with 3-cycle in_valid gaps between pixels -> exactly 12 out_valid pulses; windows identical to the gapless run; out_window held during gaps.
5. Frame 1 of all 0xFF, then reset at (2,1), then 2 pixels without sof, then a ramp frame with sof:
   - the 2 pixels give no out_valid;
   - the (0,0) and (1,1) windows match cases 1/2, with no 0xFF visible.
6. Edge cases:
   - 5 pixels with no eol -> 5th pixel reports x=0, y=1.
   - sof+eol on one pixel -> next pixel is (0,1).
   - sof injected at (2,1) -> that pixel reports (0,0), out_sof=1.
